// File: rtl/tagged_flux_fifo.sv
// Bank of per-flux circular queues; the tag selects the queue on push and is rebuilt from the queue index on read.
// Write-to-read latency is 1 cycle. One shared full flag stalls every push, and a held word must be retried.
module tagged_flux_fifo #(
    parameter int FLUX       = 2,
    parameter int DATA_WIDTH = 7,
    parameter int DEPTH      = 4,
    parameter int TAG_WIDTH  = $clog2(FLUX),
    parameter int WIDTH      = DATA_WIDTH + TAG_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             write,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic [FLUX-1:0]  read,
    output logic [FLUX-1:0]  empty,
    output logic [WIDTH-1:0] dout
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);

    logic [TAG_WIDTH-1:0]              tag;
    logic [DATA_WIDTH-1:0]             data;
    logic                              wr_ok;
    logic [FLUX-1:0]                   lvl_full;
    logic [FLUX-1:0][DATA_WIDTH-1:0]   head;

    assign tag   = din[WIDTH-1 -: TAG_WIDTH];
    assign data  = din[DATA_WIDTH-1:0];
    assign full  = |lvl_full;
    assign wr_ok = write & ~full;

    genvar f;
    generate
        for (f = 0; f < FLUX; f++) begin : g_flux
            localparam logic [TAG_WIDTH-1:0] TAG_IDX = TAG_WIDTH'(f);

            logic [DATA_WIDTH-1:0] mem [DEPTH];
            logic [PW-1:0]         wp;
            logic [PW-1:0]         rp;
            logic [CW-1:0]         cnt;
            logic                  push;
            logic                  pop;

            // Tags with no matching queue never match any TAG_IDX, so they are dropped here.
            assign push = wr_ok && (tag == TAG_IDX);
            assign pop  = read[f] && (cnt != '0);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wp  <= '0;
                    rp  <= '0;
                    cnt <= '0;
                end else begin
                    if (push) begin
                        wp <= (wp == LAST_PTR) ? '0 : wp + PW'(1);
                    end
                    if (pop) begin
                        rp <= (rp == LAST_PTR) ? '0 : rp + PW'(1);
                    end
                    case ({push, pop})
                        2'b10:   cnt <= cnt + CW'(1);
                        2'b01:   cnt <= cnt - CW'(1);
                        default: cnt <= cnt;
                    endcase
                end
            end

            always_ff @(posedge clk) begin
                if (push) begin
                    mem[wp] <= data;
                end
            end

            assign empty[f]    = (cnt == '0);
            assign lvl_full[f] = (cnt == CNT_MAX);
            assign head[f]     = mem[rp];
        end
    endgenerate

    // Scan from the top so the lowest-index non-empty flux wins; all-empty yields zero.
    always_comb begin
        dout = '0;
        for (int i = FLUX - 1; i >= 0; i--) begin
            if (!empty[i]) begin
                dout = {TAG_WIDTH'(i), head[i]};
            end
        end
    end

endmodule

// File: tb/tb_tagged_flux_fifo.sv
// Directed bench for tagged_flux_fifo: a 2-flux instance for the main behaviour and a 3-flux one for illegal tags.
module tb_tagged_flux_fifo;

    logic       clk;
    logic       rst_n;
    logic       write;
    logic [7:0] din;
    logic       full;
    logic [1:0] read;
    logic [1:0] empty;
    logic [7:0] dout;

    logic       b_write;
    logic [8:0] b_din;
    logic       b_full;
    logic [2:0] b_read;
    logic [2:0] b_empty;
    logic [8:0] b_dout;

    int checks = 0;
    int errors = 0;

    tagged_flux_fifo #(.FLUX(2), .DATA_WIDTH(7), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .write(write), .din(din), .full(full),
        .read(read), .empty(empty), .dout(dout)
    );

    tagged_flux_fifo #(.FLUX(3), .DATA_WIDTH(7), .DEPTH(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .write(b_write), .din(b_din), .full(b_full),
        .read(b_read), .empty(b_empty), .dout(b_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] w);
        write = 1'b1;
        din   = w;
        tick();
        write = 1'b0;
        din   = '0;
    endtask

    task automatic pop(input logic [1:0] r);
        read = r;
        tick();
        read = '0;
    endtask

    initial begin
        rst_n = 1'b0; write = 1'b0; din = '0; read = '0;
        b_write = 1'b0; b_din = '0; b_read = '0;
        #12;
        chk("rst_empty", 32'(empty), 32'h3);
        chk("rst_full",  32'(full),  32'h0);
        chk("rst_dout",  32'(dout),  32'h0);
        rst_n = 1'b1;
        tick();

        // Mid-stream reset with three words queued on flux 0
        push(8'h01); push(8'h02); push(8'h03);
        chk("pre_rst_empty", 32'(empty), 32'h2);
        chk("pre_rst_dout",  32'(dout),  32'h01);
        rst_n = 1'b0;
        #1;
        chk("midrst_empty", 32'(empty), 32'h3);
        chk("midrst_full",  32'(full),  32'h0);
        chk("midrst_dout",  32'(dout),  32'h0);
        #2;
        rst_n = 1'b1;
        tick();
        pop(2'b11);
        chk("postrst_pop_empty", 32'(empty), 32'h3);
        chk("postrst_pop_dout",  32'(dout),  32'h0);

        // Priority and tag reconstruction
        push(8'h94);
        push(8'h05);
        chk("prio_dout0",  32'(dout),  32'h05);
        chk("prio_empty0", 32'(empty), 32'h0);
        pop(2'b01);
        chk("prio_dout1",  32'(dout),  32'h94);
        chk("prio_empty1", 32'(empty), 32'h1);
        pop(2'b10);
        chk("prio_empty2", 32'(empty), 32'h3);
        chk("prio_dout2",  32'(dout),  32'h0);

        // Fill flux 0, drop a push while full, free one slot
        push(8'h0A); push(8'h0B); push(8'h0C);
        chk("full_at3", 32'(full), 32'h0);
        push(8'h0D);
        chk("full_at4", 32'(full), 32'h1);
        push(8'h09);
        chk("full_hold", 32'(full), 32'h1);
        chk("full_head", 32'(dout), 32'h0A);
        pop(2'b01);
        chk("full_freed", 32'(full), 32'h0);
        chk("full_dout",  32'(dout), 32'h0B);
        push(8'h83);
        chk("full_f1_acc", 32'(empty), 32'h0);
        pop(2'b01);
        chk("drain_c", 32'(dout), 32'h0C);
        pop(2'b01);
        chk("drain_d", 32'(dout), 32'h0D);
        pop(2'b01);
        chk("drain_no9", 32'(dout), 32'h83);
        pop(2'b10);
        chk("drain_empty", 32'(empty), 32'h3);

        // Wrap-around on flux 1 with sustained push+pop
        push(8'h80);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("wrap_%0d", i), 32'(dout), 32'(8'h80 | 8'(i)));
            write = (i < 9);
            din   = 8'h80 | 8'(i + 1);
            read  = 2'b10;
            tick();
            write = 1'b0; din = '0; read = '0;
        end
        chk("wrap_empty", 32'(empty), 32'h3);

        // Same-flux push and pop together keeps the count
        push(8'h1E); push(8'h1F);
        write = 1'b1; din = 8'h2C; read = 2'b01;
        tick();
        write = 1'b0; din = '0; read = '0;
        chk("sim_dout0", 32'(dout), 32'h1F);
        pop(2'b01);
        chk("sim_dout1", 32'(dout), 32'h2C);
        pop(2'b01);
        chk("sim_empty", 32'(empty), 32'h3);

        // Two fluxes popped in the same cycle
        push(8'h01); push(8'h02); push(8'h87); push(8'h88);
        pop(2'b11);
        chk("dual_dout0",  32'(dout),  32'h02);
        chk("dual_empty0", 32'(empty), 32'h0);
        pop(2'b01);
        chk("dual_dout1", 32'(dout), 32'h88);
        pop(2'b10);
        chk("dual_empty1", 32'(empty), 32'h3);

        // Illegal tag on the 3-flux instance
        b_write = 1'b1; b_din = 9'h181;
        tick();
        b_write = 1'b0; b_din = '0;
        chk("illegal_empty", 32'(b_empty), 32'h7);
        chk("illegal_dout",  32'(b_dout),  32'h0);
        chk("illegal_full",  32'(b_full),  32'h0);
        b_write = 1'b1; b_din = 9'h101;
        tick();
        b_write = 1'b0; b_din = '0;
        chk("tag2_empty", 32'(b_empty), 32'h3);
        chk("tag2_dout",  32'(b_dout),  32'h101);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
